// File: rtl/dnn_layer_sequencer.sv
// Layer sequencer for the 1024-64-10 binary-input digit classifier.
// Walks every neuron of both layers, drives the pixel/weight/bias/hidden-RAM
// addresses, owns the shared accumulator, quantises hidden activations and
// performs the final argmax over the output classes.
module dnn_layer_sequencer #(
    parameter int unsigned IMG_BITS = 1024,
    parameter int unsigned HID_N    = 64,
    parameter int unsigned OUT_N    = 10,
    parameter int unsigned W_W      = 8,
    parameter int unsigned ACC_W    = 24,
    parameter int unsigned H_SHIFT  = 4
) (
    input  logic                                           sysClk,
    input  logic                                           iRst_n,
    input  logic                                           start,
    output logic [$clog2(IMG_BITS)-1:0]                    img_addr,
    input  logic                                           img_bit,
    output logic [$clog2(HID_N*IMG_BITS+OUT_N*HID_N)-1:0]  w_addr,
    input  logic signed [W_W-1:0]                          w_data,
    output logic [$clog2(HID_N+OUT_N)-1:0]                 b_addr,
    input  logic signed [ACC_W-1:0]                        b_data,
    output logic                                           h_we,
    output logic [$clog2(HID_N)-1:0]                       h_waddr,
    output logic [7:0]                                     h_wdata,
    output logic [$clog2(HID_N)-1:0]                       h_raddr,
    input  logic [7:0]                                     h_rdata,
    output logic                                           busy,
    output logic                                           done,
    output logic [3:0]                                     num_out
);

    localparam int unsigned IW   = $clog2(IMG_BITS);
    localparam int unsigned WAW  = $clog2(HID_N*IMG_BITS+OUT_N*HID_N);
    localparam int unsigned BW   = $clog2(HID_N+OUT_N);
    localparam int unsigned HW   = $clog2(HID_N);
    localparam int unsigned CW   = $clog2((IMG_BITS > HID_N) ? IMG_BITS : HID_N) + 1;
    localparam int unsigned PW   = W_W + 9;
    localparam int unsigned L2_W = HID_N * IMG_BITS;
    localparam logic signed [ACC_W-1:0] H_MAX = ACC_W'(255);

    typedef enum logic [3:0] {
        IDLE, L1_BIAS, L1_ACC, L1_DRAIN, L1_WB,
        L2_BIAS, L2_ACC, L2_DRAIN, L2_CMP, DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [HW-1:0]            n_q, n_d;
    logic [3:0]               k_q, k_d;
    logic [CW-1:0]            i_q, i_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  best_q, best_d;
    logic [3:0]               idx_q, idx_d;
    logic                     pix_q;
    logic [IW-1:0]            img_addr_q, img_addr_d;
    logic [WAW-1:0]           w_addr_q, w_addr_d;
    logic [BW-1:0]            b_addr_q, b_addr_d;
    logic [HW-1:0]            h_raddr_q, h_raddr_d;
    logic [HW-1:0]            h_waddr_q, h_waddr_d;
    logic [7:0]               h_wdata_q, h_wdata_d;
    logic                     h_we_q, h_we_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [3:0]               num_out_q, num_out_d;

    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  term_l1, term_l2, shifted;

    // Next-state, accumulator datapath and next values of all registered outputs
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        k_d        = k_q;
        i_d        = i_q;
        acc_d      = acc_q;
        best_d     = best_q;
        idx_d      = idx_q;
        num_out_d  = num_out_q;
        img_addr_d = img_addr_q;
        w_addr_d   = w_addr_q;
        b_addr_d   = b_addr_q;
        h_raddr_d  = h_raddr_q;
        h_waddr_d  = h_waddr_q;
        h_wdata_d  = h_wdata_q;

        // Data returning this cycle belongs to the index issued last cycle
        prod    = w_data * $signed({1'b0, h_rdata});
        term_l1 = pix_q ? {{(ACC_W-W_W){w_data[W_W-1]}}, w_data} : '0;
        term_l2 = {{(ACC_W-PW){prod[PW-1]}}, prod};

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = L1_BIAS;
                    n_d       = '0;
                    k_d       = '0;
                    i_d       = '0;
                    acc_d     = '0;
                    num_out_d = '0;
                end
            end
            L1_BIAS: begin
                state_d = L1_ACC;
                i_d     = '0;
            end
            L1_ACC: begin
                acc_d = (i_q == '0) ? b_data : acc_q + term_l1;
                if (i_q == CW'(IMG_BITS-1)) state_d = L1_DRAIN;
                else                         i_d     = i_q + 1'b1;
            end
            L1_DRAIN: begin
                acc_d   = acc_q + term_l1;
                state_d = L1_WB;
            end
            L1_WB: begin
                if (n_q == HW'(HID_N-1)) begin
                    state_d = L2_BIAS;
                    k_d     = '0;
                end else begin
                    n_d     = n_q + 1'b1;
                    state_d = L1_BIAS;
                end
            end
            L2_BIAS: begin
                state_d = L2_ACC;
                i_d     = '0;
            end
            L2_ACC: begin
                acc_d = (i_q == '0) ? b_data : acc_q + term_l2;
                if (i_q == CW'(HID_N-1)) state_d = L2_DRAIN;
                else                      i_d     = i_q + 1'b1;
            end
            L2_DRAIN: begin
                acc_d   = acc_q + term_l2;
                state_d = L2_CMP;
            end
            L2_CMP: begin
                // Strict compare: ties keep the lowest class index
                if (k_q == '0 || acc_q > best_q) begin
                    best_d = acc_q;
                    idx_d  = k_q;
                end
                if (k_q == 4'(OUT_N-1)) begin
                    state_d   = DONE;
                    num_out_d = idx_d;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = L2_BIAS;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered
        shifted = acc_d >>> H_SHIFT;
        case (state_d)
            L1_BIAS: b_addr_d = BW'(n_d);
            L2_BIAS: b_addr_d = BW'(HID_N + k_d);
            L1_ACC: begin
                img_addr_d = IW'(i_d);
                w_addr_d   = WAW'(n_d * IMG_BITS + i_d);
            end
            L2_ACC: begin
                h_raddr_d = HW'(i_d);
                w_addr_d  = WAW'(L2_W + k_d * HID_N + i_d);
            end
            L1_WB: begin
                h_waddr_d = n_q;
                if (shifted < 0)          h_wdata_d = 8'd0;
                else if (shifted > H_MAX) h_wdata_d = 8'd255;
                else                      h_wdata_d = shifted[7:0];
            end
            default: ;
        endcase
        h_we_d = (state_d == L1_WB);
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge sysClk) begin
        if (!iRst_n) begin
            state_q    <= IDLE;
            n_q        <= '0;
            k_q        <= '0;
            i_q        <= '0;
            acc_q      <= '0;
            best_q     <= '0;
            idx_q      <= '0;
            pix_q      <= 1'b0;
            img_addr_q <= '0;
            w_addr_q   <= '0;
            b_addr_q   <= '0;
            h_raddr_q  <= '0;
            h_waddr_q  <= '0;
            h_wdata_q  <= '0;
            h_we_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            num_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            k_q        <= k_d;
            i_q        <= i_d;
            acc_q      <= acc_d;
            best_q     <= best_d;
            idx_q      <= idx_d;
            pix_q      <= img_bit;
            img_addr_q <= img_addr_d;
            w_addr_q   <= w_addr_d;
            b_addr_q   <= b_addr_d;
            h_raddr_q  <= h_raddr_d;
            h_waddr_q  <= h_waddr_d;
            h_wdata_q  <= h_wdata_d;
            h_we_q     <= h_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            num_out_q  <= num_out_d;
        end
    end

    assign img_addr = img_addr_q;
    assign w_addr   = w_addr_q;
    assign b_addr   = b_addr_q;
    assign h_raddr  = h_raddr_q;
    assign h_waddr  = h_waddr_q;
    assign h_wdata  = h_wdata_q;
    assign h_we     = h_we_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign num_out  = num_out_q;

endmodule

// File: tb/tb_dnn_layer_sequencer.sv
// Directed bench for dnn_layer_sequencer using a reduced network
// (32 pixels -> 4 hidden -> 10 classes) so every run takes 211 cycles.
module tb_dnn_layer_sequencer;

    localparam int unsigned IMG_BITS = 32;
    localparam int unsigned HID_N    = 4;
    localparam int unsigned OUT_N    = 10;
    localparam int unsigned W_W      = 8;
    localparam int unsigned ACC_W    = 24;
    localparam int unsigned H_SHIFT  = 4;
    localparam int unsigned IW       = $clog2(IMG_BITS);
    localparam int unsigned WDEPTH   = HID_N*IMG_BITS + OUT_N*HID_N;
    localparam int unsigned WAW      = $clog2(WDEPTH);
    localparam int unsigned BW       = $clog2(HID_N+OUT_N);
    localparam int unsigned HW       = $clog2(HID_N);
    localparam int unsigned L2OFF    = HID_N*IMG_BITS;
    // Start-to-done latency: 1 + HID_N*(IMG_BITS+3) + OUT_N*(HID_N+3)
    localparam int          RUN_CYC  = 211;

    logic                    sysClk = 1'b0;
    logic                    iRst_n;
    logic                    start;
    logic [IW-1:0]           img_addr;
    logic                    img_bit;
    logic [WAW-1:0]          w_addr;
    logic signed [W_W-1:0]   w_data;
    logic [BW-1:0]           b_addr;
    logic signed [ACC_W-1:0] b_data;
    logic                    h_we;
    logic [HW-1:0]           h_waddr;
    logic [7:0]              h_wdata;
    logic [HW-1:0]           h_raddr;
    logic [7:0]              h_rdata;
    logic                    busy;
    logic                    done;
    logic [3:0]              num_out;

    logic                    img_mem [IMG_BITS];
    logic signed [W_W-1:0]   wrom [WDEPTH];
    logic signed [ACC_W-1:0] brom [HID_N+OUT_N];
    logic [7:0]              hram [HID_N];
    logic [HW-1:0]           wlog_a [256];
    logic [7:0]              wlog_d [256];
    int                      wcnt = 0;

    int vectors = 0;
    int miscompares = 0;

    dnn_layer_sequencer #(
        .IMG_BITS (IMG_BITS),
        .HID_N    (HID_N),
        .OUT_N    (OUT_N),
        .W_W      (W_W),
        .ACC_W    (ACC_W),
        .H_SHIFT  (H_SHIFT)
    ) dut (
        .sysClk   (sysClk),
        .iRst_n   (iRst_n),
        .start    (start),
        .img_addr (img_addr),
        .img_bit  (img_bit),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .h_we     (h_we),
        .h_waddr  (h_waddr),
        .h_wdata  (h_wdata),
        .h_raddr  (h_raddr),
        .h_rdata  (h_rdata),
        .busy     (busy),
        .done     (done),
        .num_out  (num_out)
    );

    always #5 sysClk = ~sysClk;

    assign img_bit = img_mem[img_addr];

    // Synchronous ROM/RAM models plus a log of every hidden write
    always @(posedge sysClk) begin
        w_data  <= wrom[w_addr];
        b_data  <= brom[b_addr];
        h_rdata <= hram[h_raddr];
        if (h_we) begin
            hram[h_waddr]        <= h_wdata;
            wlog_a[wcnt[7:0]]    <= h_waddr;
            wlog_d[wcnt[7:0]]    <= h_wdata;
            wcnt                 <= wcnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int unsigned x = 0; x < IMG_BITS; x++) img_mem[x] = 1'b0;
        for (int unsigned x = 0; x < WDEPTH; x++) wrom[x] = '0;
        for (int unsigned x = 0; x < HID_N+OUT_N; x++) brom[x] = '0;
    endtask

    // One start pulse, optional extra start pulse at cycle pulse_at, then
    // measure the done latency and final class
    task automatic run_expect(input string tag, input logic [3:0] exp_num, input int pulse_at);
        int cyc;
        @(negedge sysClk);
        start = 1'b1;
        @(posedge sysClk);
        #1 start = 1'b0;
        cyc = 1;
        while (cyc < 2000) begin
            @(negedge sysClk);
            if (cyc == 1) begin
                check({tag, "_busy_early"}, 32'(busy), 32'd1);
                check({tag, "_done_early"}, 32'(done), 32'd0);
            end
            if (done) break;
            start = (cyc == pulse_at);
            @(posedge sysClk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, 32'(cyc), 32'(RUN_CYC));
        check({tag, "_num_out"}, 32'(num_out), 32'(exp_num));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        logic [7:0] exp_h [4];

        iRst_n = 1'b0;
        start  = 1'b0;
        clear_mem();
        repeat (3) @(posedge sysClk);
        @(negedge sysClk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_num", 32'(num_out), 32'd0);
        check("rst_h_we", 32'(h_we), 32'd0);
        check("rst_img_addr", 32'(img_addr), 32'd0);
        check("rst_w_addr", 32'(w_addr), 32'd0);
        check("rst_b_addr", 32'(b_addr), 32'd0);
        iRst_n = 1'b1;

        // Single positive class bias wins
        brom[HID_N+7] = 24'sd50;
        run_expect("t1", 4'd7, 0);

        // All classes equal: lowest index wins
        for (int unsigned x = 0; x < OUT_N; x++) brom[HID_N+x] = 24'sd5;
        run_expect("t2", 4'd0, 0);

        // Hidden quantisation: negative clamps to 0, large saturates to 255
        clear_mem();
        brom[0] = -24'sd100;
        brom[1] = 24'sd8000;
        brom[2] = 24'sd80;
        exp_h[0] = 8'd0; exp_h[1] = 8'd255; exp_h[2] = 8'd5; exp_h[3] = 8'd0;
        base = wcnt;
        run_expect("t3", 4'd0, 0);
        check("t3_h_we_count", 32'(wcnt - base), 32'(HID_N));
        for (int unsigned j = 0; j < HID_N; j++) begin
            check("t3_h_waddr", 32'(wlog_a[8'(base + int'(j))]), 32'(j));
            check("t3_h_wdata", 32'(wlog_d[8'(base + int'(j))]), 32'(exp_h[j]));
        end

        // All pixels set, L1 weights 1: each hidden = 32>>>4 = 2; class 3 acc = 8
        clear_mem();
        for (int unsigned x = 0; x < IMG_BITS; x++) img_mem[x] = 1'b1;
        for (int unsigned x = 0; x < L2OFF; x++) wrom[x] = 8'sd1;
        for (int unsigned j = 0; j < HID_N; j++) wrom[L2OFF + 3*HID_N + j] = 8'sd1;
        base = wcnt;
        run_expect("t4", 4'd3, 0);
        for (int unsigned j = 0; j < HID_N; j++)
            check("t4_h_wdata", 32'(wlog_d[8'(base + int'(j))]), 32'd2);

        // Negative weights and negative scores: class 3 = -28, class 8 = -15 wins
        for (int unsigned j = 0; j < HID_N; j++) wrom[L2OFF + 3*HID_N + j] = -8'sd1;
        for (int unsigned x = 0; x < OUT_N; x++) brom[HID_N+x] = -24'sd20;
        brom[HID_N+8] = -24'sd15;
        run_expect("t4b", 4'd8, 0);

        // Start pulse mid-L1 is ignored
        run_expect("t5_pulse", 4'd8, 50);

        // Reset just before the first hidden write-back cycle
        @(negedge sysClk);
        start = 1'b1;
        @(posedge sysClk);
        #1 start = 1'b0;
        repeat (33) @(posedge sysClk);
        @(negedge sysClk);
        iRst_n = 1'b0;
        @(posedge sysClk);
        @(negedge sysClk);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_h_we", 32'(h_we), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        iRst_n = 1'b1;
        run_expect("t5_after_rst", 4'd8, 0);

        // Restart from DONE with a new stimulus
        clear_mem();
        brom[HID_N+7] = 24'sd50;
        run_expect("t6", 4'd7, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
